efb_wb_arbiter: RTL and testbench
=================================

// Module: efb_wb_arbiter
// PURPOSE
//  Shares the single 8-bit Wishbone slave port of the EFB (I2C1/I2C2/SPI/timer/UFM) between two
//  iomem-style requesters: port 0 = picorv32 iomem window 0x04xx_xxxx, port 1 = hardware sequencer.
//  Converts each 32-bit iomem access into one Wishbone classic cycle, arbitrates round-robin, and
//  bounds every cycle with a timeout so a hung EFB never stalls the CPU.
// PARAMETERS
//  TIMEOUT_CYCLES  255           max cycles cyc/stb held without wb_ack before abort (1..65535)
//  ERR_WORD        32'h00BADADD  rdata returned on timeout
//  ADDR_LSB        2             lowest iomem addr bit mapped to wb_adr[0] (word-per-register)
// PORTS
//  clk           in   1   system clock (all logic, including EFB Wishbone, on this clock)
//  reset         in   1   synchronous, active-high reset
//  m0_valid      in   1   requester 0 access request, held until m0_ready
//  m0_ready      out  1   requester 0 completion, 1-cycle pulse
//  m0_wstrb      in   4   requester 0 byte strobes; 0 = read
//  m0_addr       in   32  requester 0 address
//  m0_wdata      in   32  requester 0 write data (bits 7:0 used)
//  m0_rdata      out  32  requester 0 read data, valid with m0_ready
//  m1_valid/m1_ready/m1_wstrb/m1_addr/m1_wdata/m1_rdata  same as port 0, requester 1
//  wb_cyc        out  1   Wishbone cycle
//  wb_stb        out  1   Wishbone strobe (identical to wb_cyc)
//  wb_we         out  1   Wishbone write enable
//  wb_adr        out  8   Wishbone address = addr[ADDR_LSB+7:ADDR_LSB]
//  wb_dat_o      out  8   Wishbone write data = wdata[7:0]
//  wb_dat_i      in   8   Wishbone read data
//  wb_ack        in   1   Wishbone acknowledge
//  timeout_err   out  1   1-cycle pulse when a cycle is aborted by timeout
// BEHAVIOUR
//  - All outputs registered. Reset: all ready/cyc/stb/we/timeout_err = 0, rdata = 0, wb_adr/dat_o = 0,
//    state = IDLE, rr pointer = port 0 preferred, timeout counter = 0.
//  - States: IDLE -> BUS -> DONE -> IDLE.
//  - IDLE: if any valid, grant: only one valid -> that port; both -> port != last granted.
//    Latch we = wstrb[0], adr, dat_o from granted port; cyc=stb=1 next cycle; go BUS; record grant.
//  - BUS: hold cyc/stb/we/adr/dat_o stable; counter increments each cycle.
//    wb_ack -> cyc=stb=0, granted ready=1, rdata={24'h0,wb_dat_i}; go DONE.
//    counter == TIMEOUT_CYCLES-1 without ack -> cyc=stb=0, ready=1, rdata=ERR_WORD,
//    timeout_err=1; go DONE. Ack on the expiry cycle wins (normal completion).
//  - DONE: ready deasserts; one dead cycle so the requester drops valid; no new grant; -> IDLE.
//  - Latency (no contention): valid@T0 -> cyc/stb@T1; ack@Tk -> ready@Tk+1. Min 3 cycles
//    (ack in T1); back-to-back grants to the same port spaced >= 4 cycles.
//  - Ungranted port waits; round-robin guarantees it the next grant. Max wait = one full access.
//  - rdata of the non-granted port is not updated. Writes also return {24'h0,wb_dat_i}.
//  - wb_ack in IDLE/DONE ignored. valid dropping mid-BUS: cycle completes normally, ready still pulses.
//  - reset in any state: abort at that edge, cyc/stb low next cycle, no ready pulse issued.
// STRUCTURE
//  - Shared package femto_wb_pkg: state enum (IDLE, BUS, DONE), ERR_WORD default, grant index type.
//  - One sub-module: rr_arbiter2 (2-way round-robin grant with last-grant register, updated on grant only).
//  - Datapath muxing, FSM and timeout counter in this module; counter width $clog2(TIMEOUT_CYCLES+1).
// TESTING
//  1. m0 read addr 0x0400_0148, slave acks 2 cycles after stb with 0x5A -> wb_adr=0x52, we=0,
//     m0_ready one cycle, m0_rdata=0x0000005A.
//  2. m1 write wstrb=4'h1 wdata=0x000000C3 addr 0x0400_0004 -> we=1, adr=0x01, dat_o=0xC3; m0 idle.
//  3. m0,m1 valid same cycle, continuously re-requesting -> grants alternate 0,1,0,1; neither starves.
//  4. TIMEOUT_CYCLES=8, slave never acks -> cyc drops after 8 cycles, timeout_err pulse,
//     rdata=0x00BADADD; next request served normally.
//  5. reset asserted 1 cycle mid-BUS -> cyc/stb/ready low next cycle, state IDLE, pointer to port 0.
//  6. Ack on the exact timeout cycle -> normal data returned, no timeout_err.

Source files
------------

// File: rtl/femto_wb_pkg.sv
// Shared types and constants for the EFB Wishbone arbiter.
package femto_wb_pkg;

  localparam int unsigned WB_ADR_W  = 8;
  localparam int unsigned WB_DAT_W  = 8;
  localparam int unsigned IOMEM_W   = 32;
  localparam int unsigned STRB_W    = 4;

  localparam logic [IOMEM_W-1:0] ERR_WORD_DEFAULT = 32'h00BADADD;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Index of a requester port (0 = CPU iomem window, 1 = sequencer).
  typedef logic gnt_idx_t;

endpackage

// File: rtl/efb_wb_arbiter_if.sv
// Wishbone classic bus between the arbiter (master) and the EFB (slave).
interface efb_wb_arbiter_if;
  import femto_wb_pkg::*;

  logic                wb_cyc;
  logic                wb_stb;
  logic                wb_we;
  logic [WB_ADR_W-1:0] wb_adr;
  logic [WB_DAT_W-1:0] wb_dat_o;
  logic [WB_DAT_W-1:0] wb_dat_i;
  logic                wb_ack;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o,
    input  wb_dat_i, wb_ack
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o,
    output wb_dat_i, wb_ack
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; the last-grant register moves only when a grant is taken.
module rr_arbiter2
  import femto_wb_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic [1:0] i_req,
  input  logic     i_gnt_en,
  output gnt_idx_t o_gnt_idx_c,
  output logic     o_gnt_valid_c
);

  gnt_idx_t r_last;

  // Pick the requester that was not served last when both ask.
  always_comb begin
    o_gnt_valid_c = |i_req;
    o_gnt_idx_c   = 1'b0;
    if (i_req == 2'b11) begin
      o_gnt_idx_c = ~r_last;
    end else if (i_req[1]) begin
      o_gnt_idx_c = 1'b1;
    end
  end

  // Remember the last granted port; reset value makes port 0 preferred.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= 1'b1;
    end else if (i_gnt_en) begin
      r_last <= o_gnt_idx_c;
    end
  end

endmodule

// File: rtl/efb_wb_arbiter.sv
// Shares the EFB 8-bit Wishbone slave between two iomem requesters with a bounded cycle time.
module efb_wb_arbiter
  import femto_wb_pkg::*;
#(
  parameter int unsigned          TIMEOUT_CYCLES = 255,
  parameter logic [IOMEM_W-1:0]   ERR_WORD       = ERR_WORD_DEFAULT,
  parameter int unsigned          ADDR_LSB       = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               m0_valid,
  output logic               m0_ready,
  input  logic [STRB_W-1:0]  m0_wstrb,
  input  logic [IOMEM_W-1:0] m0_addr,
  input  logic [IOMEM_W-1:0] m0_wdata,
  output logic [IOMEM_W-1:0] m0_rdata,
  input  logic               m1_valid,
  output logic               m1_ready,
  input  logic [STRB_W-1:0]  m1_wstrb,
  input  logic [IOMEM_W-1:0] m1_addr,
  input  logic [IOMEM_W-1:0] m1_wdata,
  output logic [IOMEM_W-1:0] m1_rdata,
  efb_wb_arbiter_if.master   wb,
  output logic               timeout_err
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t              r_state, w_state_nxt;
  logic                r_cyc, w_cyc_nxt;
  logic                r_we, w_we_nxt;
  logic [WB_ADR_W-1:0] r_adr, w_adr_nxt;
  logic [WB_DAT_W-1:0] r_dat_o, w_dat_o_nxt;
  logic [1:0]          r_ready, w_ready_nxt;
  logic [IOMEM_W-1:0]  r_rdata0, w_rdata0_nxt;
  logic [IOMEM_W-1:0]  r_rdata1, w_rdata1_nxt;
  logic                r_terr, w_terr_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  gnt_idx_t            r_gidx, w_gidx_nxt;

  gnt_idx_t            w_arb_idx;
  logic                w_arb_valid;
  logic                w_gnt_en;
  logic [STRB_W-1:0]   w_sel_wstrb;
  logic [IOMEM_W-1:0]  w_sel_addr;
  logic [IOMEM_W-1:0]  w_sel_wdata;
  logic [IOMEM_W-1:0]  w_rsp_data;
  logic                w_unused;

  rr_arbiter2 u_rr (
    .clk           (clk),
    .reset         (reset),
    .i_req         ({m1_valid, m0_valid}),
    .i_gnt_en      (w_gnt_en),
    .o_gnt_idx_c   (w_arb_idx),
    .o_gnt_valid_c (w_arb_valid)
  );

  // Request fields of the port the arbiter is offering this cycle.
  assign w_sel_wstrb = w_arb_idx ? m1_wstrb : m0_wstrb;
  assign w_sel_addr  = w_arb_idx ? m1_addr  : m0_addr;
  assign w_sel_wdata = w_arb_idx ? m1_wdata : m0_wdata;
  assign w_rsp_data  = {24'h0, wb.wb_dat_i};

  // Only wstrb[0], the mapped address byte and wdata[7:0] reach the EFB.
  assign w_unused = ^{m0_wstrb, m0_addr, m0_wdata, m1_wstrb, m1_addr, m1_wdata};

  // Next state and next register values for the IDLE -> BUS -> DONE access sequence.
  always_comb begin
    w_state_nxt  = r_state;
    w_cyc_nxt    = r_cyc;
    w_we_nxt     = r_we;
    w_adr_nxt    = r_adr;
    w_dat_o_nxt  = r_dat_o;
    w_ready_nxt  = 2'b00;
    w_rdata0_nxt = r_rdata0;
    w_rdata1_nxt = r_rdata1;
    w_terr_nxt   = 1'b0;
    w_cnt_nxt    = '0;
    w_gidx_nxt   = r_gidx;
    w_gnt_en     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_arb_valid) begin
          w_gnt_en    = 1'b1;
          w_gidx_nxt  = w_arb_idx;
          w_cyc_nxt   = 1'b1;
          w_we_nxt    = w_sel_wstrb[0];
          w_adr_nxt   = w_sel_addr[ADDR_LSB +: WB_ADR_W];
          w_dat_o_nxt = w_sel_wdata[WB_DAT_W-1:0];
          w_state_nxt = ST_BUS;
        end
      end
      ST_BUS: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        // An ack on the expiry cycle still counts as normal completion.
        if (wb.wb_ack || (r_cnt == CNT_LAST)) begin
          w_cyc_nxt           = 1'b0;
          w_cnt_nxt           = '0;
          w_ready_nxt[r_gidx] = 1'b1;
          w_terr_nxt          = ~wb.wb_ack;
          w_state_nxt         = ST_DONE;
          if (r_gidx) begin
            w_rdata1_nxt = wb.wb_ack ? w_rsp_data : ERR_WORD;
          end else begin
            w_rdata0_nxt = wb.wb_ack ? w_rsp_data : ERR_WORD;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any cycle in flight without a ready pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cyc    <= 1'b0;
      r_we     <= 1'b0;
      r_adr    <= '0;
      r_dat_o  <= '0;
      r_ready  <= 2'b00;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_terr   <= 1'b0;
      r_cnt    <= '0;
      r_gidx   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cyc    <= w_cyc_nxt;
      r_we     <= w_we_nxt;
      r_adr    <= w_adr_nxt;
      r_dat_o  <= w_dat_o_nxt;
      r_ready  <= w_ready_nxt;
      r_rdata0 <= w_rdata0_nxt;
      r_rdata1 <= w_rdata1_nxt;
      r_terr   <= w_terr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_gidx   <= w_gidx_nxt;
    end
  end

  assign wb.wb_cyc   = r_cyc;
  assign wb.wb_stb   = r_cyc;
  assign wb.wb_we    = r_we;
  assign wb.wb_adr   = r_adr;
  assign wb.wb_dat_o = r_dat_o;
  assign m0_ready    = r_ready[0];
  assign m1_ready    = r_ready[1];
  assign m0_rdata    = r_rdata0;
  assign m1_rdata    = r_rdata1;
  assign timeout_err = r_terr;

endmodule

// File: tb/tb_efb_wb_arbiter.sv
// Bench for efb_wb_arbiter: vector table, hand-written corner sequences, randomized traffic.
module tb_efb_wb_arbiter;
  import femto_wb_pkg::*;

  localparam logic [31:0] ERR = 32'h00BADADD;
  localparam int          TO  = 8;

  typedef struct {
    logic [7:0] adr;
    logic       we;
    logic [7:0] dout;
    int         d;
    logic [7:0] di;
  } bus_t;

  typedef struct {
    int          p;
    logic [3:0]  st;
    logic [31:0] a;
    logic [31:0] wd;
    int          d;
    logic [7:0]  di;
    logic [7:0]  e_adr;
    logic        e_we;
    logic [7:0]  e_dout;
    logic [31:0] e_rd;
    int          e_terr;
    int          e_lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_valid, m1_valid;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_ready, m1_ready, terr;
  logic [31:0] m0_rdata, m1_rdata;

  always #5 clk = ~clk;

  efb_wb_arbiter_if bus ();

  efb_wb_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .m0_valid    (m0_valid),
    .m0_ready    (m0_ready),
    .m0_wstrb    (m0_wstrb),
    .m0_addr     (m0_addr),
    .m0_wdata    (m0_wdata),
    .m0_rdata    (m0_rdata),
    .m1_valid    (m1_valid),
    .m1_ready    (m1_ready),
    .m1_wstrb    (m1_wstrb),
    .m1_addr     (m1_addr),
    .m1_wdata    (m1_wdata),
    .m1_rdata    (m1_rdata),
    .wb          (bus.master),
    .timeout_err (terr)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          r0_cnt = 0, r1_cnt = 0, te_cnt = 0;
  int          sl_mode = 0, sl_fix_d = 0, sl_n = 0, sl_d = 0;
  logic [7:0]  sl_fix_di = 8'h00, sl_di = 8'h00;
  bit          sl_noise = 1'b0;
  bus_t        cur;
  bus_t        log_q[$];
  int          model_last;
  logic [31:0] exp_rd[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  // Requester side: hold valid until ready, report data and cycles from valid to ready.
  task automatic access(input int p, input logic [3:0] st, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output int lat);
    bit got;
    got = 1'b0;
    rd  = 32'h0;
    lat = 0;
    @(posedge clk); #1;
    if (p == 0) begin
      m0_valid = 1'b1; m0_wstrb = st; m0_addr = a; m0_wdata = wd;
    end else begin
      m1_valid = 1'b1; m1_wstrb = st; m1_addr = a; m1_wdata = wd;
    end
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      lat++;
      if (((p == 0) ? m0_ready : m1_ready) === 1'b1) begin
        rd  = (p == 0) ? m0_rdata : m1_rdata;
        got = 1'b1;
        break;
      end
    end
    if (p == 0) m0_valid = 1'b0; else m1_valid = 1'b0;
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL access_wait port%0d: no ready after %0d cycles, want ready within 64", p, lat);
    end
  endtask

  // EFB model: acks after a chosen number of cyc cycles and checks the bus stays stable.
  always @(negedge clk) begin
    chk("stb_eq_cyc", 32'(bus.wb_stb), 32'(bus.wb_cyc));
    if (bus.wb_cyc === 1'b1) begin
      if (sl_n == 0) begin
        sl_d     = (sl_mode == 1) ? int'($urandom_range(0, 9)) : sl_fix_d;
        sl_di    = (sl_mode == 1) ? 8'($urandom) : sl_fix_di;
        cur.adr  = bus.wb_adr;
        cur.we   = bus.wb_we;
        cur.dout = bus.wb_dat_o;
        cur.d    = sl_d;
        cur.di   = sl_di;
        log_q.push_back(cur);
      end else begin
        chk("adr_stable", 32'(bus.wb_adr), 32'(cur.adr));
        chk("we_stable", 32'(bus.wb_we), 32'(cur.we));
        chk("dat_o_stable", 32'(bus.wb_dat_o), 32'(cur.dout));
      end
      bus.wb_ack   = (sl_n == sl_d);
      bus.wb_dat_i = sl_di;
      sl_n++;
    end else begin
      sl_n         = 0;
      bus.wb_ack   = sl_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.wb_dat_i = 8'($urandom);
    end
  end

  // Pulse counters for ready and timeout_err.
  always @(negedge clk) begin
    if (m0_ready === 1'b1) r0_cnt++;
    if (m1_ready === 1'b1) r1_cnt++;
    if (terr === 1'b1) te_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

  initial begin
    vec_t        tv[8];
    bus_t        e;
    logic [31:0] rd, ex;
    int          lat, b_r0, b_r1, b_te, oth;
    logic [3:0]  st[2];
    logic [31:0] a[2], wd[2], rr[2];
    int          ll[2], ord[2], n, nto, mask, exp_lat;

    tv[0] = '{0, 4'h0, 32'h0400_0148, 32'h0000_0000, 2,    8'h5A, 8'h52, 1'b0, 8'h00, 32'h0000_005A, 0, 4};
    tv[1] = '{1, 4'h1, 32'h0400_0004, 32'h0000_00C3, 1,    8'h77, 8'h01, 1'b1, 8'hC3, 32'h0000_0077, 0, 3};
    tv[2] = '{0, 4'h0, 32'h0400_0000, 32'h0000_0000, 1000, 8'h11, 8'h00, 1'b0, 8'h00, 32'h00BA_DADD, 1, 9};
    tv[3] = '{0, 4'h0, 32'h0400_03FC, 32'h0000_0000, 0,    8'hA5, 8'hFF, 1'b0, 8'h00, 32'h0000_00A5, 0, 2};
    tv[4] = '{1, 4'h0, 32'h0400_0010, 32'h0000_0000, 7,    8'h3C, 8'h04, 1'b0, 8'h00, 32'h0000_003C, 0, 9};
    tv[5] = '{1, 4'h0, 32'h0400_0020, 32'h0000_0000, 8,    8'h99, 8'h08, 1'b0, 8'h00, 32'h00BA_DADD, 1, 9};
    tv[6] = '{0, 4'hE, 32'h0400_0400, 32'h0000_00FF, 3,    8'h42, 8'h00, 1'b0, 8'hFF, 32'h0000_0042, 0, 5};
    tv[7] = '{1, 4'hF, 32'h0400_0088, 32'h1234_5667, 0,    8'h00, 8'h22, 1'b1, 8'h67, 32'h0000_0000, 0, 2};

    reset = 1'b1;
    m0_valid = 1'b0; m0_wstrb = 4'h0; m0_addr = 32'h0; m0_wdata = 32'h0;
    m1_valid = 1'b0; m1_wstrb = 4'h0; m1_addr = 32'h0; m1_wdata = 32'h0;
    bus.wb_ack = 1'b0; bus.wb_dat_i = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cyc", 32'(bus.wb_cyc), 32'h0);
    chk("rst_we", 32'(bus.wb_we), 32'h0);
    chk("rst_adr", 32'(bus.wb_adr), 32'h0);
    chk("rst_dat_o", 32'(bus.wb_dat_o), 32'h0);
    chk("rst_ready", 32'({m1_ready, m0_ready}), 32'h0);
    chk("rst_rdata0", m0_rdata, 32'h0);
    chk("rst_rdata1", m1_rdata, 32'h0);
    chk("rst_terr", 32'(terr), 32'h0);
    reset = 1'b0;
    model_last = 1;
    exp_rd[0] = 32'h0;
    exp_rd[1] = 32'h0;

    // Single-requester vectors: reads, writes, timeout, ack on the expiry cycle.
    for (int i = 0; i < 8; i++) begin
      sl_mode = 0; sl_fix_d = tv[i].d; sl_fix_di = tv[i].di;
      b_r0 = r0_cnt; b_r1 = r1_cnt; b_te = te_cnt;
      oth = 1 - tv[i].p;
      access(tv[i].p, tv[i].st, tv[i].a, tv[i].wd, rd, lat);
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("v%0d_log_count", i), 32'(log_q.size()), 32'd1);
      if (log_q.size() > 0) begin
        e = log_q.pop_front();
        chk($sformatf("v%0d_adr", i), 32'(e.adr), 32'(tv[i].e_adr));
        chk($sformatf("v%0d_we", i), 32'(e.we), 32'(tv[i].e_we));
        chk($sformatf("v%0d_dat_o", i), 32'(e.dout), 32'(tv[i].e_dout));
      end
      chk($sformatf("v%0d_rdata", i), rd, tv[i].e_rd);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(tv[i].e_lat));
      chk($sformatf("v%0d_timeout_err", i), 32'(te_cnt - b_te), 32'(tv[i].e_terr));
      chk($sformatf("v%0d_ready_pulses_p0", i), 32'(r0_cnt - b_r0), (tv[i].p == 0) ? 32'd1 : 32'd0);
      chk($sformatf("v%0d_ready_pulses_p1", i), 32'(r1_cnt - b_r1), (tv[i].p == 1) ? 32'd1 : 32'd0);
      chk($sformatf("v%0d_other_rdata", i), (oth == 0) ? m0_rdata : m1_rdata, exp_rd[oth]);
      exp_rd[tv[i].p] = tv[i].e_rd;
      model_last = tv[i].p;
    end

    // Both ports re-requesting continuously: grants must alternate.
    sl_mode = 0; sl_fix_d = 1; sl_fix_di = 8'hC0;
    log_q.delete();
    fork
      begin : req0
        logic [31:0] rd_a;
        int          lat_a;
        for (int k = 0; k < 3; k++) begin
          access(0, 4'h0, 32'h0400_0040 + 32'(k * 4), 32'h0, rd_a, lat_a);
          chk($sformatf("rr_p0_rdata%0d", k), rd_a, 32'h0000_00C0);
        end
      end
      begin : req1
        logic [31:0] rd_b;
        int          lat_b;
        for (int k = 0; k < 3; k++) begin
          access(1, 4'h0, 32'h0400_0080 + 32'(k * 4), 32'h0, rd_b, lat_b);
          chk($sformatf("rr_p1_rdata%0d", k), rd_b, 32'h0000_00C0);
        end
      end
    join
    repeat (2) @(posedge clk);
    #1;
    chk("rr_log_count", 32'(log_q.size()), 32'd6);
    for (int j = 0; j < 6; j++) begin
      int pp;
      pp = (model_last + 1 + j) % 2;
      if (log_q.size() > 0) begin
        e = log_q.pop_front();
        chk($sformatf("rr_order%0d", j), 32'(e.adr), 32'(((pp == 0) ? 8'h10 : 8'h20) + 8'(j / 2)));
      end
    end
    model_last = (model_last + 6) % 2;
    exp_rd[0] = 32'h0000_00C0;
    exp_rd[1] = 32'h0000_00C0;

    // Reset while the bus cycle is outstanding.
    sl_mode = 0; sl_fix_d = 1000;
    b_r0 = r0_cnt; b_te = te_cnt;
    @(posedge clk); #1;
    m0_valid = 1'b1; m0_wstrb = 4'h0; m0_addr = 32'h0400_0100; m0_wdata = 32'h0;
    @(posedge clk); #1;
    chk("rst_mid_cyc_before", 32'(bus.wb_cyc), 32'h1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m0_valid = 1'b0;
    chk("rst_mid_cyc", 32'(bus.wb_cyc), 32'h0);
    chk("rst_mid_stb", 32'(bus.wb_stb), 32'h0);
    chk("rst_mid_ready", 32'(m0_ready), 32'h0);
    chk("rst_mid_rdata0", m0_rdata, 32'h0);
    @(posedge clk); #1;
    chk("rst_mid_cyc_idle", 32'(bus.wb_cyc), 32'h0);
    chk("rst_mid_no_ready", 32'(r0_cnt - b_r0), 32'h0);
    chk("rst_mid_no_terr", 32'(te_cnt - b_te), 32'h0);
    model_last = 1;
    exp_rd[0] = 32'h0;
    exp_rd[1] = 32'h0;
    log_q.delete();

    // After reset, simultaneous requests go to port 0 first.
    sl_fix_d = 0; sl_fix_di = 8'h5C;
    fork
      access(0, 4'h0, 32'h0400_0200, 32'h0, rr[0], ll[0]);
      access(1, 4'h0, 32'h0400_0300, 32'h0, rr[1], ll[1]);
    join
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_log_count", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) begin
      e = log_q.pop_front();
      chk("post_rst_first_adr", 32'(e.adr), 32'h80);
      e = log_q.pop_front();
      chk("post_rst_second_adr", 32'(e.adr), 32'hC0);
    end
    chk("post_rst_lat0", 32'(ll[0]), 32'd2);
    chk("post_rst_lat1", 32'(ll[1]), 32'd5);
    chk("post_rst_rd0", rr[0], 32'h0000_005C);
    model_last = 1;
    exp_rd[0] = 32'h0000_005C;
    exp_rd[1] = 32'h0000_005C;
    log_q.delete();

    // Random traffic against the round-robin/timeout reference model, with stray acks when idle.
    sl_mode = 1; sl_noise = 1'b1;
    for (int it = 0; it < 40; it++) begin
      mask = int'($urandom_range(1, 3));
      for (int p = 0; p < 2; p++) begin
        st[p] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
        a[p]  = 32'h0400_0000 | ($urandom & 32'h0000_0FFC);
        wd[p] = $urandom;
        rr[p] = 32'h0;
        ll[p] = 0;
      end
      b_te = te_cnt;
      fork
        begin if (mask[0]) access(0, st[0], a[0], wd[0], rr[0], ll[0]); end
        begin if (mask[1]) access(1, st[1], a[1], wd[1], rr[1], ll[1]); end
      join
      repeat (2) @(posedge clk);
      #1;
      n = (mask == 3) ? 2 : 1;
      if (mask == 3) ord[0] = (model_last == 0) ? 1 : 0;
      else           ord[0] = (mask == 1) ? 0 : 1;
      ord[1] = 1 - ord[0];
      chk($sformatf("rnd%0d_log_count", it), 32'(log_q.size()), 32'(n));
      nto = 0;
      exp_lat = 0;
      for (int j = 0; j < n; j++) begin
        int pp;
        pp = ord[j];
        if (log_q.size() > 0) begin
          e = log_q.pop_front();
          ex = (e.d < TO) ? {24'h0, e.di} : ERR;
          exp_lat = exp_lat + ((j > 0) ? 1 : 0) + ((e.d < TO) ? e.d + 2 : TO + 1);
          if (e.d >= TO) nto++;
          chk($sformatf("rnd%0d_adr%0d", it, j), 32'(e.adr), 32'(8'(a[pp] >> 2)));
          chk($sformatf("rnd%0d_we%0d", it, j), 32'(e.we), 32'(st[pp][0]));
          chk($sformatf("rnd%0d_dat_o%0d", it, j), 32'(e.dout), 32'(wd[pp][7:0]));
          chk($sformatf("rnd%0d_rdata%0d", it, j), rr[pp], ex);
          chk($sformatf("rnd%0d_lat%0d", it, j), 32'(ll[pp]), 32'(exp_lat));
          exp_rd[pp] = ex;
        end
      end
      if (n == 1) begin
        chk($sformatf("rnd%0d_other_rdata", it), (ord[1] == 0) ? m0_rdata : m1_rdata, exp_rd[ord[1]]);
      end
      chk($sformatf("rnd%0d_timeouts", it), 32'(te_cnt - b_te), 32'(nto));
      model_last = ord[n - 1];
    end
    sl_noise = 1'b0;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
